lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side companion to the team's length-6 XNOR LFSR pattern generator (feedback: new bit = tap5 XNOR tap6).
- Consumes a serial bit stream, self-synchronises to the sequence, then checks every later bit against the locally predicted bit.
- Reports lock status, per-bit error strobes and a saturating error count.
- Sits at a serial link or loopback output as a PRBS-6 BER checker.

Parameters:
- WIN, 32, length of the error-monitoring window in checked bits (power of 2, 8..256).
- THRESH, 4, errors within one window that cause loss of lock (1..WIN).
- CW, 16, width of the saturating error and bit counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- x_in  input  1  serial data bit under test.
- x_vld  input  1  x_in qualifier; the checker advances only when high.
- clr  input  1  synchronous clear of err_cnt and bit_cnt; lock state is kept.
- locked  output  1  high while in the LOCKED state.
- err  output  1  one-cycle strobe, mismatch on the previous valid bit.
- err_cnt  output  CW  saturating count of mismatches while locked.
- bit_cnt  output  CW  saturating count of bits checked while locked.

Behaviour:
- Reset values: sr=0, state=SEARCH, locked=0, err=0, err_cnt=0, bit_cnt=0, load count=0, window count=0, window errors=0.
- Shift register sr[6:1]: on every x_vld, sr[1]<=x_in and sr[i]<=sr[i-1]. The register does not move when x_vld=0.
- Predicted bit p = sr[5] XNOR sr[6].
- SEARCH:
  - Counts valid bits loaded, 0..6.
  - On the 6th valid bit, the next state is examined (sr with x_in shifted in).
  - If that state is all-ones (XNOR lockup), the load count resets to 0 and the block stays in SEARCH.
  - Otherwise it moves to LOCKED; locked=1 from the next cycle.
  - No err and no counting in SEARCH.
- LOCKED:
  - Each valid bit is compared, mismatch = x_in XOR p.
  - err<=mismatch, registered with 1-cycle latency; err=0 in cycles without x_vld.
  - bit_cnt increments and err_cnt increments on mismatch; both saturate at 2^CW-1.
  - The received bit, not p, is shifted into sr, so a single bit error produces up to 3 err strobes (bit itself plus taps 5/6 later).
- Window:
  - Window counter counts valid checked bits 0..WIN-1; window error counter counts mismatches, saturating at THRESH.
  - Counters restart at wrap. On the wrap cycle, that bit's mismatch is counted in the closing window.
  - When the window error count reaches THRESH, lock is lost the same cycle, with err still asserted for that bit.
  - Lock-loss handling depends on the optional feature below.
- clr:
  - Zeroes err_cnt and bit_cnt.
  - clr with a simultaneous increment gives 0 (clr wins).
- reset mid-operation: all state returns to reset values on the next edge, regardless of x_vld.
- The block has no backpressure; x_vld may be high every cycle.

Optional Feature:
- Macro LFSR_CHK_AUTO_RESYNC_EN.
- Defined: loss of lock returns to SEARCH. The load count and window counters clear, and reacquisition restarts with the next valid bit. err_cnt and bit_cnt are kept.
- Undefined: loss of lock enters FAULT. locked=0, err=0, counters frozen, inputs ignored, until reset. A clr in FAULT still zeroes the counters.

Test Plan:
- Stream from generator started at state 000000 (bits 1,1,1,1,1,0,1,...), x_vld=1 continuously:
  - locked rises the cycle after the 6th bit.
  - After 63 further bits: bit_cnt=63, err_cnt=0, err never high.
- Constant x_in=1 for 100 valid bits -> every load yields all-ones; locked stays 0 and err_cnt=0.
- Locked stream, bit 20 after lock inverted -> err strobes on checked bits 20, 25 and 26; err_cnt=3; locked remains 1 (THRESH=4).
- Locked stream, bits 10, 12, 14 and 16 inverted (within one 32-bit window):
  - locked falls in the cycle the 4th error is counted.
  - With LFSR_CHK_AUTO_RESYNC_EN: relock 6 valid bits later.
  - Without it: stays 0 until reset.
- x_vld toggling 1,0,1,0 on a clean locked stream -> same result as continuous; bit_cnt equals the number of valid bits and err=0.
- Locked with err_cnt=5: assert clr with a mismatching bit -> err_cnt=0 and locked=1. Assert reset mid-stream -> all outputs 0 next cycle, and reacquisition takes 6 valid bits.

Source files
------------

// File: rtl/lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr_checker - self-synchronising PRBS-6 (XNOR, taps 5/6) BER checker.   |
// | Option macro: LFSR_CHK_AUTO_RESYNC_EN (lock loss -> SEARCH, else FAULT).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lfsr_checker #(
  parameter int WIN    = 32,
  parameter int THRESH = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_in,
  input  logic          x_vld,
  input  logic          clr,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] bit_cnt
);

  localparam int WCW = $clog2(WIN);
  localparam int WEW = $clog2(THRESH + 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_FAULT  = 2'd2;

  localparam logic [CW-1:0]  C_CNT_MAX  = '1;
  localparam logic [WCW-1:0] C_WIN_LAST = WCW'(WIN - 1);
  localparam logic [WEW-1:0] C_THRESH   = WEW'(THRESH);

  logic [1:0]     state_q, state_d;
  logic [6:1]     sr_q, sr_d;
  logic [2:0]     load_q, load_d;
  logic [WCW-1:0] win_q, win_d;
  logic [WEW-1:0] werr_q, werr_d;
  logic           err_q, err_d;
  logic [CW-1:0]  ecnt_q, ecnt_d;
  logic [CW-1:0]  bcnt_q, bcnt_d;

  logic [6:1]     w_sr_shift;
  logic           w_pred;
  logic           w_mis;
  logic [WEW-1:0] w_werr_inc;

  // The received bit (not the prediction) feeds the register, so errors echo at taps 5/6.
  assign w_sr_shift = {sr_q[5:1], x_in};
  assign w_pred     = ~(sr_q[5] ^ sr_q[6]);
  assign w_mis      = x_in ^ w_pred;
  assign w_werr_inc = (w_mis && (werr_q != C_THRESH)) ? werr_q + WEW'(1) : werr_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    load_d  = load_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    bcnt_d  = bcnt_q;

    case (state_q)
      S_SEARCH: begin
        if (x_vld) begin
          sr_d = w_sr_shift;
          if (load_q == 3'd5) begin
            load_d = 3'd0;
            // An all-ones register is the XNOR lockup state and never a valid seed.
            if (w_sr_shift != 6'h3f) begin
              state_d = S_LOCKED;
            end
          end else begin
            load_d = load_q + 3'd1;
          end
        end
      end

      S_LOCKED: begin
        if (x_vld) begin
          sr_d  = w_sr_shift;
          err_d = w_mis;
          if (bcnt_q != C_CNT_MAX) begin
            bcnt_d = bcnt_q + CW'(1);
          end
          if (w_mis && (ecnt_q != C_CNT_MAX)) begin
            ecnt_d = ecnt_q + CW'(1);
          end
          if (w_werr_inc == C_THRESH) begin
`ifdef LFSR_CHK_AUTO_RESYNC_EN
            state_d = S_SEARCH;
            load_d  = 3'd0;
            win_d   = '0;
            werr_d  = '0;
`else
            state_d = S_FAULT;
            werr_d  = w_werr_inc;
`endif
          end else if (win_q == C_WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WCW'(1);
            werr_d = w_werr_inc;
          end
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_SEARCH;
      end
    endcase

    if (clr) begin
      ecnt_d = '0;
      bcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SEARCH;
      sr_q    <= '0;
      load_q  <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      load_q  <= load_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign locked  = (state_q == S_LOCKED);
  assign err     = err_q;
  assign err_cnt = ecnt_q;
  assign bit_cnt = bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lfsr_checker - scoreboard bench for lfsr_checker (PRBS-6 XNOR stream). |
// | Honours LFSR_CHK_AUTO_RESYNC_EN the same way as the design.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lfsr_checker;

  localparam int WIN     = 32;
  localparam int THRESH  = 4;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          x_in;
  logic          x_vld;
  logic          clr;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] bit_cnt;

  lfsr_checker #(.WIN(WIN), .THRESH(THRESH), .CW(CW)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .x_in    (x_in),
    .x_vld   (x_vld),
    .clr     (clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit er;
    int ec;
    int bc;
  } exp_t;

  exp_t   sb[$];
  int     inv_q[$];
  int     n_chk;
  int     n_fail;
  bit     err_seen;

  // Reference generator and behavioural checker model.
  bit [6:1] g;
  int       m_state;
  bit [6:1] m_sr;
  int       m_load, m_win, m_werr, m_ecnt, m_bcnt;
  bit       m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic gen_bit(output bit b);
    b = !(g[5] ^ g[6]);
    g = {g[5:1], b};
  endtask

  task automatic model_step(input bit x, input bit v, input bit c, input bit r);
    bit p, mis;
    m_err = 1'b0;
    if (r) begin
      m_state = 0; m_sr = '0; m_load = 0; m_win = 0; m_werr = 0; m_ecnt = 0; m_bcnt = 0;
      return;
    end
    p   = !(m_sr[5] ^ m_sr[6]);
    mis = x ^ p;
    if (v && m_state == 0) begin
      m_sr = {m_sr[5:1], x};
      m_load++;
      if (m_load == 6) begin
        m_load = 0;
        if (m_sr != 6'h3f) m_state = 1;
      end
    end else if (v && m_state == 1) begin
      m_sr  = {m_sr[5:1], x};
      m_err = mis;
      if (m_bcnt < CNT_MAX) m_bcnt++;
      if (mis && m_ecnt < CNT_MAX) m_ecnt++;
      m_werr += int'(mis);
      m_win++;
      if (m_werr >= THRESH) begin
`ifdef LFSR_CHK_AUTO_RESYNC_EN
        m_state = 0; m_load = 0; m_win = 0; m_werr = 0;
`else
        m_state = 2;
`endif
      end else if (m_win == WIN) begin
        m_win = 0; m_werr = 0;
      end
    end
    if (c) begin
      m_ecnt = 0; m_bcnt = 0;
    end
  endtask

  task automatic compare_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("sb_locked", locked, e.lk);
      check_val("sb_err", err, e.er);
      check_val("sb_err_cnt", err_cnt, e.ec);
      check_val("sb_bit_cnt", bit_cnt, e.bc);
      if (err === 1'b1) err_seen = 1'b1;
    end
  endtask

  task automatic drive(input bit x, input bit v, input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    compare_pending();
    x_in = x; x_vld = v; clr = c; reset = r;
    model_step(x, v, c, r);
    e.lk = (m_state == 1);
    e.er = m_err;
    e.ec = m_ecnt;
    e.bc = m_bcnt;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    g = '0;
    inv_q = {};
  endtask

  // Sends n generator bits; checked-bit index k0+i is inverted when listed in inv_q.
  task automatic send_gen(input int n, input int k0, input bit c, input bit tog);
    bit b, flip;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      flip = 1'b0;
      foreach (inv_q[j]) if (inv_q[j] == k0 + i) flip = 1'b1;
      drive(b ^ flip, 1'b1, c, 1'b0);
      if (tog) idle();
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; x_in = 1'b0; x_vld = 1'b0; clr = 1'b0;
    n_chk = 0; n_fail = 0; err_seen = 1'b0; g = '0;
    m_state = 0; m_sr = '0; m_load = 0; m_win = 0; m_werr = 0; m_ecnt = 0; m_bcnt = 0; m_err = 0;

    do_reset();
    do_reset();
    idle();
    check_val("rst_locked", locked, 0);
    check_val("rst_err", err, 0);
    check_val("rst_err_cnt", err_cnt, 0);
    check_val("rst_bit_cnt", bit_cnt, 0);

    // Clean stream: lock on the 6th bit, then 63 clean checks.
    send_gen(6, -100, 1'b0, 1'b0);
    check_val("clean_unlocked_after5", locked, 0);
    idle();
    check_val("clean_locked_after6", locked, 1);
    err_seen = 1'b0;
    send_gen(63, 1, 1'b0, 1'b0);
    idle();
    check_val("clean_bit_cnt", bit_cnt, 63);
    check_val("clean_err_cnt", err_cnt, 0);
    check_val("clean_err_seen", err_seen, 0);

    // Constant ones never escape the lockup state.
    do_reset();
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    check_val("ones_locked", locked, 0);
    check_val("ones_err_cnt", err_cnt, 0);

    // Single inverted bit -> three echoes, lock kept.
    do_reset();
    send_gen(6, -100, 1'b0, 1'b0);
    inv_q = '{20};
    send_gen(30, 1, 1'b0, 1'b0);
    idle();
    check_val("single_err_cnt", err_cnt, 3);
    check_val("single_locked", locked, 1);

    // Four errors in one window -> lock loss on checked bit 15.
    do_reset();
    send_gen(6, -100, 1'b0, 1'b0);
    inv_q = '{10, 12, 14, 16};
    send_gen(14, 1, 1'b0, 1'b0);
    idle();
    check_val("burst_pre_locked", locked, 1);
    check_val("burst_pre_err_cnt", err_cnt, 3);
    send_gen(1, 15, 1'b0, 1'b0);
    idle();
    check_val("burst_loss_locked", locked, 0);
    check_val("burst_loss_err", err, 1);
    check_val("burst_loss_err_cnt", err_cnt, 4);
    send_gen(6, 16, 1'b0, 1'b0);
    idle();
`ifdef LFSR_CHK_AUTO_RESYNC_EN
    check_val("burst_relock", locked, 1);
    send_gen(20, 22, 1'b0, 1'b0);
    idle();
`else
    check_val("burst_fault_locked", locked, 0);
    send_gen(10, 22, 1'b0, 1'b0);
    idle();
    check_val("fault_frozen_err_cnt", err_cnt, 4);
    check_val("fault_frozen_bit_cnt", bit_cnt, 15);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check_val("fault_clr_err_cnt", err_cnt, 0);
    check_val("fault_clr_bit_cnt", bit_cnt, 0);
`endif

    // Gapped valid: 40 checked bits interleaved with idle cycles.
    do_reset();
    send_gen(6, -100, 1'b0, 1'b0);
    err_seen = 1'b0;
    send_gen(40, 1, 1'b0, 1'b1);
    idle();
    check_val("gap_bit_cnt", bit_cnt, 40);
    check_val("gap_err_cnt", err_cnt, 0);
    check_val("gap_err_seen", err_seen, 0);

    // err_cnt=5 across two windows, then clr beats a simultaneous mismatch.
    do_reset();
    send_gen(6, -100, 1'b0, 1'b0);
    inv_q = '{10, 40};
    send_gen(45, 1, 1'b0, 1'b0);
    idle();
    check_val("pre_clr_err_cnt", err_cnt, 5);
    check_val("pre_clr_locked", locked, 1);
    send_gen(1, 46, 1'b1, 1'b0);
    idle();
    check_val("clr_err_cnt", err_cnt, 0);
    check_val("clr_bit_cnt", bit_cnt, 0);
    check_val("clr_err", err, 1);
    check_val("clr_locked", locked, 1);

    // Reset mid-stream with x_vld high, then reacquire from the running stream.
    begin
      bit b;
      gen_bit(b);
      drive(b, 1'b1, 1'b0, 1'b1);
    end
    idle();
    check_val("midrst_locked", locked, 0);
    check_val("midrst_err", err, 0);
    check_val("midrst_err_cnt", err_cnt, 0);
    check_val("midrst_bit_cnt", bit_cnt, 0);
    send_gen(6, -100, 1'b0, 1'b0);
    check_val("reacq_unlocked_after5", locked, 0);
    idle();
    check_val("reacq_locked_after6", locked, 1);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
